// File: rtl/phy_reset_sequencer.sv
// phy_reset_sequencer
//   Brings up the GMII PHY: holds phy_reset_n low for RESET_CYCLES, waits
//   SETTLE_CYCLES after release, then raises phy_ready.  Soft re-reset
//   requests restart the sequence and are counted (saturating at 255).
//
//   Optional feature macro: PHY_WATCHDOG_EN
//     When defined, a link watchdog re-resets the PHY after WATCHDOG_CYCLES
//     consecutive RUN cycles without rx_activity.  When undefined no watchdog
//     logic exists and rx_activity is ignored.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   soft_reset_req in   single-cycle re-reset request
//   rx_activity    in   one pulse per valid RX byte (clk domain)
//   phy_reset_n    out  PHY hardware reset, active low, registered
//   phy_ready      out  high while in RUN, registered
//   busy           out  high in HOLD or SETTLE, registered
//   reset_count    out  soft + watchdog re-resets since rst, saturating
module phy_reset_sequencer #(
    parameter int unsigned RESET_CYCLES    = 1250000,
    parameter int unsigned SETTLE_CYCLES   = 6250000,
    parameter int unsigned WATCHDOG_CYCLES = 125000000,
    parameter int unsigned CNT_WIDTH       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_reset_req,
    input  logic       rx_activity,
    output logic       phy_reset_n,
    output logic       phy_ready,
    output logic       busy,
    output logic [7:0] reset_count
);

    localparam logic [1:0] HOLD   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [CNT_WIDTH-1:0] RESET_LAST  = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST     = CNT_WIDTH'(WATCHDOG_CYCLES - 1);

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] next_counter;
    logic                 wd_trip;
    logic                 go_hold;

    // In RUN the interval counter is otherwise idle, so it doubles as the
    // watchdog counter; it is zero on RUN entry because every state change
    // clears it.
    always_comb begin
        next_state   = state;
        next_counter = counter;
        wd_trip      = 1'b0;
        case (state)
            HOLD: begin
                if (counter == RESET_LAST) begin
                    next_state   = SETTLE;
                    next_counter = '0;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end
            SETTLE: begin
                if (counter == SETTLE_LAST) begin
                    next_state   = RUN;
                    next_counter = '0;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end
            RUN: begin
`ifdef PHY_WATCHDOG_EN
                wd_trip      = !rx_activity && (counter == WD_LAST);
                next_counter = rx_activity ? '0 : counter + 1'b1;
`else
                next_counter = '0;
`endif
            end
            default: begin
                next_state   = HOLD;
                next_counter = '0;
            end
        endcase

        // A request and a watchdog trip on the same cycle collapse into one
        // re-reset; either overrides a terminal count.
        go_hold = soft_reset_req | wd_trip;
        if (go_hold) begin
            next_state   = HOLD;
            next_counter = '0;
        end
    end

`ifndef PHY_WATCHDOG_EN
    logic unused_watchdog;
    assign unused_watchdog = ^{rx_activity, WD_LAST};
`endif

    // Outputs are registered from the current state, so a terminal count
    // becomes visible one edge after the state change (phy_reset_n rises at
    // edge RESET_CYCLES+1).  A re-reset is decoded from go_hold so that it
    // takes effect on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOLD;
            counter     <= '0;
            phy_reset_n <= 1'b0;
            phy_ready   <= 1'b0;
            busy        <= 1'b1;
            reset_count <= '0;
        end else begin
            state       <= next_state;
            counter     <= next_counter;
            phy_reset_n <= (state != HOLD) && !go_hold;
            phy_ready   <= (state == RUN) && !go_hold;
            busy        <= (state != RUN) || go_hold;
            if (go_hold && (reset_count != 8'hFF)) begin
                reset_count <= reset_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_phy_reset_sequencer.sv
// Directed testbench for phy_reset_sequencer with RESET_CYCLES=10,
// SETTLE_CYCLES=20, WATCHDOG_CYCLES=50.  Builds with or without
// PHY_WATCHDOG_EN; watchdog expectations follow the macro.
module tb_phy_reset_sequencer;

`ifdef PHY_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       soft_reset_req;
    logic       rx_activity;
    logic       phy_reset_n;
    logic       phy_ready;
    logic       busy;
    logic [7:0] reset_count;

    int unsigned checks;
    int unsigned errors;
    int unsigned exp_cnt;
    int unsigned bad;

    phy_reset_sequencer #(
        .RESET_CYCLES   (10),
        .SETTLE_CYCLES  (20),
        .WATCHDOG_CYCLES(50),
        .CNT_WIDTH      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .soft_reset_req(soft_reset_req),
        .rx_activity   (rx_activity),
        .phy_reset_n   (phy_reset_n),
        .phy_ready     (phy_ready),
        .busy          (busy),
        .reset_count   (reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge k=0 is the edge that sampled rst or a re-reset; walks k=1..35.
    task automatic run_seq(input string tag);
        for (int k = 1; k <= 35; k++) begin
            tick();
            check_val({tag, ".rstn"},  32'(phy_reset_n), 32'(k >= 11));
            check_val({tag, ".busy"},  32'(busy),        32'(k < 31));
            check_val({tag, ".ready"}, 32'(phy_ready),   32'(k >= 31));
        end
        check_val({tag, ".count"}, 32'(reset_count), exp_cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bad    = 0;
        rst            = 1'b1;
        soft_reset_req = 1'b0;
        rx_activity    = 1'b1;
        repeat (3) tick();

        // Reset values
        check_val("rst.rstn",  32'(phy_reset_n), 32'd0);
        check_val("rst.ready", 32'(phy_ready),   32'd0);
        check_val("rst.busy",  32'(busy),        32'd1);
        check_val("rst.count", 32'(reset_count), 32'd0);

        // Power-up sequence
        rst = 1'b0;
        exp_cnt = 0;
        run_seq("pwrup");

        // Soft request in RUN
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        exp_cnt = 1;
        check_val("soft.rstn",  32'(phy_reset_n), 32'd0);
        check_val("soft.ready", 32'(phy_ready),   32'd0);
        check_val("soft.busy",  32'(busy),        32'd1);
        check_val("soft.count", 32'(reset_count), 32'd1);
        run_seq("soft");

        // Request at HOLD cycle 7 restarts the hold interval
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        repeat (6) tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        exp_cnt = 1;
        check_val("hold7.rstn", 32'(phy_reset_n), 32'd0);
        run_seq("hold7");

        // 300 requests spaced 5 cycles apart: saturation, ready stays low
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) begin
                repeat (4) begin
                    tick();
                    if (phy_ready !== 1'b0) bad++;
                end
            end
            soft_reset_req = 1'b1;
            tick();
            soft_reset_req = 1'b0;
            if (phy_ready !== 1'b0) bad++;
            if (i == 254) check_val("sat.c254", 32'(reset_count), 32'd254);
            if (i == 256) check_val("sat.c256", 32'(reset_count), 32'd255);
        end
        check_val("sat.ready_low", bad, 32'd0);
        exp_cnt = 255;
        run_seq("sat");

        // rst during SETTLE with reset_count=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            soft_reset_req = 1'b1;
            tick();
            soft_reset_req = 1'b0;
        end
        repeat (15) tick();
        check_val("midrst.pre_count", 32'(reset_count), 32'd3);
        check_val("midrst.pre_rstn",  32'(phy_reset_n), 32'd1);
        check_val("midrst.pre_busy",  32'(busy),        32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst.rstn",  32'(phy_reset_n), 32'd0);
        check_val("midrst.ready", 32'(phy_ready),   32'd0);
        check_val("midrst.count", 32'(reset_count), 32'd0);
        exp_cnt = 0;
        run_seq("midrst");

        // Activity every 40 cycles in RUN: no re-reset
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            rx_activity = 1'b0;
            repeat (39) begin
                tick();
                if (phy_ready !== 1'b1) bad++;
            end
            rx_activity = 1'b1;
            tick();
            if (phy_ready !== 1'b1) bad++;
        end
        check_val("wd40.ready_high", bad, 32'd0);
        check_val("wd40.count", 32'(reset_count), exp_cnt);

        // Activity stops: trip 50 cycles after the last pulse (watchdog build)
        rx_activity = 1'b0;
        repeat (49) tick();
        check_val("wdstop.49_ready", 32'(phy_ready),   32'd1);
        check_val("wdstop.49_rstn",  32'(phy_reset_n), 32'd1);
        tick();
        check_val("wdstop.50_rstn",  32'(phy_reset_n), 32'(!WD));
        check_val("wdstop.50_ready", 32'(phy_ready),   32'(!WD));
        exp_cnt = exp_cnt + 32'(WD);
        check_val("wdstop.50_count", 32'(reset_count), exp_cnt);

        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        exp_cnt++;
        run_seq("wdre");

        // Trip coincident with soft request: single increment
        rx_activity = 1'b1;
        tick();
        rx_activity = 1'b0;
        repeat (49) tick();
        check_val("coinc.pre_ready", 32'(phy_ready), 32'd1);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        exp_cnt++;
        check_val("coinc.rstn",  32'(phy_reset_n), 32'd0);
        check_val("coinc.count", 32'(reset_count), exp_cnt);
        tick();
        check_val("coinc.count_after", 32'(reset_count), exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
